// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: small byte FIFO feeding an 8N1 serialiser with THCO-style status.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_ctrl #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       tbre,
    output logic       tsre,
    output logic       overflow,
    output logic       tx
);
    localparam int                CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int                DEPTH      = 1 << FIFO_AW;
    localparam logic [CW-1:0]     BAUD_LAST  = CW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]  COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic [7:0]         mem_q [DEPTH];

    logic push, pop, baud_last;

    assign full      = (count_q == COUNT_FULL);
    assign tbre      = (count_q == '0);
    assign tsre      = (state_q == S_IDLE);
    assign overflow  = overflow_q;
    assign baud_last = (baud_q == BAUD_LAST);
    // Acceptance uses the pre-edge full flag, so a same-cycle pop never rescues a write.
    assign push      = wr_en && !full;

    // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        tx       = 1'b1;
        baud_d   = (state_q == S_IDLE || baud_last) ? '0 : baud_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!tbre) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (baud_last) begin
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx = shift_q[0];
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx = parity_q;
                if (baud_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Chaining straight into START keeps back-to-back frames gap-free.
                if (baud_last) begin
                    if (!tbre) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = wr_en && full;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: the storage array is not reset; count_q gates every read, so stale bytes are never sent.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames, a line monitor decodes tx.
// Define UART_TX_PARITY_EN to exercise the parity variant.
module tb_uart_tx_ctrl;
    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, tbre, tsre, overflow, tx;

    exp_t exp_q[$];
    int   start_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   rst_count = 0;

    uart_tx_ctrl #(.CLK_DIV(DIV), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .tbre(tbre), .tsre(tsre), .overflow(overflow), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge rst) rst_count <= rst_count + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p);
        exp_q.push_back({d, p});
    endtask

    task automatic write(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    task automatic idle_in();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int t0, input int exp_len);
        int k;
        k = 0;
        while (tsre !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (tsre !== 1'b1) check({name, "_timeout"}, tsre, 1);
        else               check(name, cycle - t0, exp_len);
    endtask

    // Line monitor: samples mid-bit after each falling edge, pops the scoreboard per frame.
    initial begin : monitor
        int         s, rc;
        logic [7:0] d;
        logic       st, par, sp;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                s  = cycle;
                rc = rst_count;
                start_q.push_back(s);
                repeat (DIV / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    d[i] = tx;
                end
                par = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                par = tx;
`endif
                repeat (DIV) @(negedge clk);
                sp = tx;
                if (rst_count == rc) begin
                    check("start_bit", st, 0);
                    check("stop_bit", sp, 1);
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("frame_data", d, e.data);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", par, e.par);
`endif
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int         n;
        logic [4:0] par_tbl;

        // Reset state, then 100 quiet cycles.
        repeat (3) @(negedge clk);
        check("reset_status", {tx, tbre, tsre, full, overflow}, 5'b11100);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("quiet_status", {tx, tbre, tsre, full, overflow}, 5'b11100);
        end

        // Single byte 0xA5: pop one edge after the write, one frame long.
        write(8'hA5);
        expect_frame(8'hA5, 1'b0);
        n = cycle + 1;
        idle_in();
        check("a5_tbre_after_write", tbre, 0);
        check("a5_tsre_before_pop", tsre, 1);
        check("a5_tx_before_pop", tx, 1);
        @(negedge clk);
        check("a5_tx_start", tx, 0);
        check("a5_tsre_after_pop", tsre, 0);
        check("a5_tbre_after_pop", tbre, 1);
        wait_idle("a5_frame_len", n + 1, FRAME);

        // Three back-to-back frames with no idle gap.
        repeat (3) @(negedge clk);
        start_q.delete();
        write(8'h01);
        expect_frame(8'h01, 1'b1);
        n = cycle + 1;
        write(8'h80);
        expect_frame(8'h80, 1'b1);
        write(8'hFF);
        expect_frame(8'hFF, 1'b0);
        idle_in();
        while (cycle < n + 2 * FRAME) @(negedge clk);
        check("b2b_tbre_before_last_pop", tbre, 0);
        @(negedge clk);
        check("b2b_tbre_after_last_pop", tbre, 1);
        check("b2b_tsre_busy", tsre, 0);
        wait_idle("b2b_total_len", n + 1, 3 * FRAME);
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_first_start", start_q[0], n + 1);
            check("b2b_gap_1_2", start_q[1] - start_q[0], FRAME);
            check("b2b_gap_2_3", start_q[2] - start_q[1], FRAME);
        end

        // Six writes: five fit (one pop frees a slot), the sixth overflows.
        repeat (3) @(negedge clk);
        par_tbl = 5'b01001;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            write(8'h10 + i[7:0]);
            if (i == 0) n = cycle + 1;
            if (i < 5)  expect_frame(8'h10 + i[7:0], par_tbl[i]);
            if (i == 4) check("ovf_full_at_3", full, 0);
            if (i == 5) begin
                check("ovf_full_at_4", full, 1);
                check("ovf_quiet_before_drop", overflow, 0);
            end
        end
        idle_in();
        check("ovf_pulse", overflow, 1);
        check("ovf_still_full", full, 1);
        @(negedge clk);
        check("ovf_pulse_one_cycle", overflow, 0);
        wait_idle("ovf_total_len", n + 1, 5 * FRAME);

        // Reset in the middle of data bit 3 of 0x3C with two bytes queued.
        repeat (3) @(negedge clk);
        write(8'h3C);
        n = cycle + 1;
        write(8'h11);
        write(8'h22);
        idle_in();
        check("abort_queued", tbre, 0);
        while (cycle < n + 1 + 18) @(negedge clk);
        #1 rst = 1'b1;
        #1 check("abort_status_async", {tx, tbre, tsre, full, overflow}, 5'b11100);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("abort_quiet_status", {tx, tbre, tsre, full, overflow}, 5'b11100);
        end

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 has odd weight, 0x03 even.
        write(8'h07);
        expect_frame(8'h07, 1'b1);
        n = cycle + 1;
        idle_in();
        @(negedge clk);
        wait_idle("par07_frame_len", n + 1, 44);
        write(8'h03);
        expect_frame(8'h03, 1'b0);
        n = cycle + 1;
        idle_in();
        @(negedge clk);
        wait_idle("par03_frame_len", n + 1, 44);
`endif

        repeat (10) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
